// File: rtl/mandel_pixel_scheduler_if.sv
// Iterator request/response and framebuffer write bundle for the Mandelbrot pixel scheduler.
// master = scheduler side, slave = iterator/framebuffer side.
interface mandel_pixel_scheduler_if #(
   parameter int ADDR_W = 19
);
   logic                c_val;
   logic                c_rdy;
   logic signed [26:0]  c_r;
   logic signed [26:0]  c_i;
   logic                res_val;
   logic                res_rdy;
   logic [10:0]         iter_count;
   logic                fb_we;
   logic [ADDR_W-1:0]   fb_addr;
   logic [7:0]          fb_data;

   modport master (
      output c_val, c_r, c_i, res_rdy, fb_we, fb_addr, fb_data,
      input  c_rdy, res_val, iter_count
   );

   modport slave (
      input  c_val, c_r, c_i, res_rdy, fb_we, fb_addr, fb_data,
      output c_rdy, res_val, iter_count
   );
endinterface

// File: rtl/mandel_pixel_scheduler.sv
// Raster-order pixel scheduler for one Mandelbrot iterator, one request in flight at a time.
// Define MANDEL_COLOR_MAP_EN to select the RGB332 bin colour lookup instead of the raw count.
module mandel_pixel_scheduler #(
   parameter int H_RES    = 640,
   parameter int V_RES    = 480,
   parameter int ITER_MAX = 1000,
   parameter int ADDR_W   = 19
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic signed [26:0]        x_origin,
   input  logic signed [26:0]        y_origin,
   input  logic signed [26:0]        step,
   mandel_pixel_scheduler_if.master  bus,
   output logic                      busy,
   output logic                      frame_done
);
   localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

   state_t             state_q, state_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic signed [26:0] c_r_q, c_r_d;
   logic signed [26:0] c_i_q, c_i_d;
   logic signed [26:0] x_org_q, x_org_d;
   logic signed [26:0] step_q, step_d;
   logic [7:0]         colour_q, colour_d;

   function automatic logic [7:0] colour_of(input logic [10:0] n);
      logic [7:0] c;
      if ({21'd0, n} >= ITER_MAX) begin
         c = 8'h00;
      end else begin
`ifdef MANDEL_COLOR_MAP_EN
         if (n < 11'd8)        c = 8'hE0;
         else if (n < 11'd16)  c = 8'hFC;
         else if (n < 11'd32)  c = 8'h1C;
         else if (n < 11'd64)  c = 8'h1F;
         else if (n < 11'd128) c = 8'h03;
         else if (n < 11'd256) c = 8'hE3;
         else                  c = 8'hFF;
`else
         // 00 is reserved for "in set", so a wrapped low byte of zero becomes 01.
         c = (n[7:0] == 8'h00) ? 8'h01 : n[7:0];
`endif
      end
      return c;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         addr_q   <= '0;
         c_r_q    <= '0;
         c_i_q    <= '0;
         x_org_q  <= '0;
         step_q   <= '0;
         colour_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         addr_q   <= addr_d;
         c_r_q    <= c_r_d;
         c_i_q    <= c_i_d;
         x_org_q  <= x_org_d;
         step_q   <= step_d;
         colour_q <= colour_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      addr_d   = addr_q;
      c_r_d    = c_r_q;
      c_i_d    = c_i_q;
      x_org_d  = x_org_q;
      step_d   = step_q;
      colour_d = colour_q;

      bus.c_val   = 1'b0;
      bus.res_rdy = 1'b0;
      bus.fb_we   = 1'b0;
      bus.c_r     = c_r_q;
      bus.c_i     = c_i_q;
      bus.fb_addr = addr_q;
      bus.fb_data = colour_q;
      busy        = (state_q != IDLE);
      frame_done  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               x_org_d = x_origin;
               step_d  = step;
               x_d     = '0;
               y_d     = '0;
               addr_d  = '0;
               c_r_d   = x_origin;
               c_i_d   = y_origin;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            bus.c_val = 1'b1;
            if (bus.c_rdy) state_d = WAIT;
         end
         WAIT: begin
            bus.res_rdy = 1'b1;
            if (bus.res_val) begin
               colour_d = colour_of(bus.iter_count);
               state_d  = WRITE;
            end
         end
         WRITE: begin
            bus.fb_we = 1'b1;
            if (x_q == X_W'(H_RES - 1) && y_q == Y_W'(V_RES - 1)) begin
               state_d = DONE;
            end else begin
               state_d = ISSUE;
               addr_d  = addr_q + 1'b1;
               // Rows run top to bottom, so the imaginary part decreases.
               if (x_q == X_W'(H_RES - 1)) begin
                  x_d   = '0;
                  y_d   = y_q + 1'b1;
                  c_r_d = x_org_q;
                  c_i_d = c_i_q - step_q;
               end else begin
                  x_d   = x_q + 1'b1;
                  c_r_d = c_r_q + step_q;
               end
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Scoreboard bench for mandel_pixel_scheduler on a 4x2 frame with a stub iterator.
// Stimulus pushes expected requests/writes; a negedge monitor pops and compares.
module tb_mandel_pixel_scheduler;
   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic signed [26:0] x_origin, y_origin, step;
   logic               busy, frame_done;

   int total = 0;
   int bad   = 0;

   mandel_pixel_scheduler_if #(.ADDR_W(3)) bus ();

   mandel_pixel_scheduler #(
      .H_RES(4), .V_RES(2), .ITER_MAX(1000), .ADDR_W(3)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .x_origin(x_origin), .y_origin(y_origin), .step(step),
      .bus(bus), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

`ifdef MANDEL_COLOR_MAP_EN
   localparam logic [7:0] C5 = 8'hE0, C37 = 8'h1F, C1000 = 8'h00, C0 = 8'hE0, C300 = 8'hFF;
`else
   localparam logic [7:0] C5 = 8'h05, C37 = 8'h25, C1000 = 8'h00, C0 = 8'h01, C300 = 8'h2C;
`endif

   // -2.0, -1.5, -1.0, -0.5 and 1.0, 0.5 in 4.23
   logic signed [26:0] xs [4] = '{-27'sd16777216, -27'sd12582912, -27'sd8388608, -27'sd4194304};
   logic signed [26:0] ys [2] = '{27'sd8388608, 27'sd4194304};

   logic [53:0] exp_req_q [$];
   logic [10:0] exp_wr_q [$];
   int          exp_done = 0;

   int req_cnt = 0, wr_cnt = 0, done_cnt = 0, stall_cycles = 0;
   int res_delay = 0;
   logic [10:0] resp_count = 11'd5;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_frame(input int nreq, input int nwr, input logic [7:0] d, input int ndone);
      for (int i = 0; i < nreq; i++) exp_req_q.push_back({xs[i % 4], ys[i / 4]});
      for (int i = 0; i < nwr; i++) exp_wr_q.push_back({3'(i), d});
      exp_done += ndone;
   endtask

   // Monitor: compares every handshake the DUT presents against the scoreboard.
   logic               prev_stall = 1'b0;
   logic signed [26:0] prev_r, prev_i;
   always @(negedge clk) begin
      if (prev_stall && !reset) begin
         chk("hold_c_val", 64'(bus.c_val), 64'd1);
         chk("hold_c", {10'd0, bus.c_r, bus.c_i}, {10'd0, prev_r, prev_i});
      end
      prev_stall = bus.c_val && !bus.c_rdy && !reset;
      if (prev_stall) stall_cycles++;
      prev_r = bus.c_r;
      prev_i = bus.c_i;
      if (bus.c_val && bus.c_rdy && !reset) begin
         req_cnt++;
         if (exp_req_q.size() == 0) chk("req_unexpected", 64'(req_cnt), 64'd0);
         else chk($sformatf("req%0d", req_cnt), {10'd0, bus.c_r, bus.c_i}, {10'd0, exp_req_q.pop_front()});
      end
      if (bus.fb_we) begin
         wr_cnt++;
         if (exp_wr_q.size() == 0) chk("wr_unexpected", 64'(wr_cnt), 64'd0);
         else chk($sformatf("wr%0d", wr_cnt), {53'd0, bus.fb_addr, bus.fb_data}, {53'd0, exp_wr_q.pop_front()});
      end
      if (frame_done) begin
         done_cnt++;
         chk("done_busy", 64'(busy), 64'd1);
         chk("done_expected", 64'(exp_done > 0), 64'd1);
         if (exp_done > 0) exp_done--;
      end
   end

   // Stub iterator: answers each accepted request after res_delay cycles.
   initial begin
      logic rf, pf, rs;
      int   cd;
      cd = -1;
      bus.res_val    = 1'b0;
      bus.iter_count = '0;
      forever begin
         @(negedge clk);
         rf = bus.c_val & bus.c_rdy;
         pf = bus.res_val & bus.res_rdy;
         rs = reset;
         @(posedge clk); #1;
         if (rs) begin
            bus.res_val = 1'b0;
            cd = -1;
         end else begin
            if (pf) bus.res_val = 1'b0;
            if (rf) cd = res_delay;
            else if (cd > 0) cd--;
            if (cd == 0) begin
               bus.res_val    = 1'b1;
               bus.iter_count = resp_count;
               cd = -1;
            end
         end
      end
   end

   task automatic wait_cnt(input string name, input int which, input int target);
      int n;
      n = 0;
      while (n < 3000) begin
         if ((which == 0 && req_cnt >= target) || (which == 1 && wr_cnt >= target)) break;
         tick();
         n++;
      end
      if (n >= 3000) chk({name, "_timeout"}, 64'd1, 64'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic finish_frame(input string name);
      int target, n;
      target = done_cnt + 1;
      n = 0;
      while (done_cnt < target && n < 3000) begin
         tick();
         n++;
      end
      chk({name, "_done_seen"}, 64'(done_cnt), 64'(target));
      chk({name, "_busy_after"}, 64'(busy), 64'd0);
      chk({name, "_queues_empty"}, 64'(exp_req_q.size() + exp_wr_q.size() + exp_done), 64'd0);
   endtask

   initial begin
      int base;
      reset = 1'b1; start = 1'b0;
      bus.c_rdy = 1'b1;
      x_origin = -27'sd16777216; y_origin = 27'sd8388608; step = 27'sd4194304;
      tick(); tick();
      reset = 1'b0;
      chk("reset_ctrl", {59'd0, bus.c_val, bus.res_rdy, bus.fb_we, busy, frame_done}, 64'd0);
      chk("reset_data", {bus.c_r, bus.c_i, bus.fb_addr, bus.fb_data}, 64'd0);

      // Frame 1: immediate count 5.
      res_delay = 0; resp_count = 11'd5;
      push_frame(8, 8, C5, 1);
      pulse_start();
      chk("busy_rise", 64'(busy), 64'd1);
      finish_frame("f1");

      // Frame 2: c_rdy low 10 cycles around pixel 2, response delay 1.
      res_delay = 1; resp_count = 11'd37; stall_cycles = 0;
      base = req_cnt;
      push_frame(8, 8, C37, 1);
      pulse_start();
      wait_cnt("f2_req", 0, base + 2);
      tick();
      bus.c_rdy = 1'b0;
      repeat (10) tick();
      bus.c_rdy = 1'b1;
      finish_frame("f2");
      chk("f2_stall_seen", 64'(stall_cycles >= 5), 64'd1);

      // Frame 3: in-set count with 50-cycle latency.
      res_delay = 50; resp_count = 11'd1000;
      push_frame(8, 8, C1000, 1);
      pulse_start();
      finish_frame("f3");

      // Frame 4: count 0, start pulsed again mid-frame must be ignored.
      res_delay = 0; resp_count = 11'd0;
      base = wr_cnt;
      push_frame(8, 8, C0, 1);
      pulse_start();
      wait_cnt("f4_wr", 1, base + 3);
      pulse_start();
      finish_frame("f4");

      // Frame 5: reset while waiting on pixel 5.
      res_delay = 50; resp_count = 11'd300;
      base = req_cnt;
      push_frame(6, 5, C300, 0);
      pulse_start();
      wait_cnt("f5_req", 0, base + 6);
      tick();
      chk("f5_in_wait", 64'(bus.res_rdy), 64'd1);
      reset = 1'b1;
      tick();
      chk("f5_reset_ctrl", {59'd0, bus.c_val, bus.res_rdy, bus.fb_we, busy, frame_done}, 64'd0);
      chk("f5_reset_data", {bus.c_r, bus.c_i, bus.fb_addr, bus.fb_data}, 64'd0);
      reset = 1'b0;
      base = done_cnt;
      repeat (80) tick();
      chk("f5_no_done", 64'(done_cnt), 64'(base));
      chk("f5_queues_empty", 64'(exp_req_q.size() + exp_wr_q.size()), 64'd0);

      // Frame 6: restart after abort begins at addr 0.
      res_delay = 0; resp_count = 11'd5;
      push_frame(8, 8, C5, 1);
      pulse_start();
      finish_frame("f6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
